// File: rtl/psg_sdm_mixer.sv
// PSG three-channel mixer with master volume and a first-order delta-sigma bitstream output.
// Define PSG_MIX_RAMP_EN to enable the stepped volume-ramp controller (default: volume loads directly).
module psg_sdm_mixer #(
    parameter int unsigned RAMP_DIV = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] aout,
    input  logic       vol_wr,
    input  logic [3:0] vol_data,
    output logic       audio_out,
    output logic [3:0] cur_vol,
    output logic       busy
);

    logic [2:0] ch_q_r;
    logic [5:0] acc_r;
    logic [5:0] sample_s;
    logic [6:0] acc_next_s;

    function automatic logic [1:0] active_channels(input logic [2:0] ch);
        return {1'b0, ch[0]} + {1'b0, ch[1]} + {1'b0, ch[2]};
    endfunction

    // Mix level: active channel count scaled by the applied volume (at most 3*15 = 45).
    always_comb begin
        sample_s   = {4'd0, active_channels(ch_q_r)} * {2'd0, cur_vol};
        acc_next_s = {1'b0, acc_r} + {1'b0, sample_s};
    end

    // Channel capture and delta-sigma accumulator; the carry out is the output bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ch_q_r    <= 3'd0;
            acc_r     <= 6'd0;
            audio_out <= 1'b0;
        end else begin
            ch_q_r    <= aout;
            acc_r     <= acc_next_s[5:0];
            audio_out <= acc_next_s[6];
        end
    end

`ifdef PSG_MIX_RAMP_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UP   = 2'd1,
        ST_DOWN = 2'd2
    } ramp_state_t;

    localparam logic [15:0] DIV_LAST_C = 16'(RAMP_DIV - 32'd1);

    ramp_state_t state_r;
    ramp_state_t state_next_s;
    logic [3:0]  target_r;
    logic [3:0]  tgt_s;
    logic [3:0]  vol_next_s;
    logic [15:0] div_r;
    logic [15:0] div_next_s;
    logic        step_s;

    // A write retargets on its own edge; the divider keeps running mid-ramp and restarts only from idle.
    always_comb begin
        tgt_s        = vol_wr ? vol_data : target_r;
        step_s       = 1'b0;
        div_next_s   = div_r;
        vol_next_s   = cur_vol;
        state_next_s = state_r;
        if (state_r == ST_IDLE) begin
            div_next_s = 16'd0;
        end else if (div_r == DIV_LAST_C) begin
            div_next_s = 16'd0;
            step_s     = (tgt_s != cur_vol);
        end else begin
            div_next_s = div_r + 16'd1;
        end
        if (step_s && (tgt_s > cur_vol)) begin
            vol_next_s = cur_vol + 4'd1;
        end else if (step_s) begin
            vol_next_s = cur_vol - 4'd1;
        end else begin
            vol_next_s = cur_vol;
        end
        if (vol_next_s == tgt_s) begin
            state_next_s = ST_IDLE;
        end else if (vol_next_s < tgt_s) begin
            state_next_s = ST_UP;
        end else begin
            state_next_s = ST_DOWN;
        end
    end

    // Ramp controller registers; busy drops on the same edge the volume reaches its target.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            target_r <= 4'd0;
            div_r    <= 16'd0;
            cur_vol  <= 4'd0;
            busy     <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            target_r <= tgt_s;
            div_r    <= div_next_s;
            cur_vol  <= vol_next_s;
            busy     <= (vol_next_s != tgt_s);
        end
    end
`else
    // Direct volume load: the written value applies from the write edge onward.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_vol <= 4'd0;
        end else if (vol_wr) begin
            cur_vol <= vol_data;
        end else begin
            cur_vol <= cur_vol;
        end
    end

    assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_psg_sdm_mixer.sv
// Self-checking bench for psg_sdm_mixer: density windows, latency, volume load/ramp and reset behaviour.
module tb_psg_sdm_mixer;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] aout;
    logic       vol_wr;
    logic [3:0] vol_data;
    logic       audio_out;
    logic [3:0] cur_vol;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    psg_sdm_mixer #(.RAMP_DIV(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .aout      (aout),
        .vol_wr    (vol_wr),
        .vol_data  (vol_data),
        .audio_out (audio_out),
        .cur_vol   (cur_vol),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic write_vol(input logic [3:0] v);
        vol_wr   = 1'b1;
        vol_data = v;
        tick();
        vol_wr   = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && busy !== 1'b0; i++) tick();
        chk("idle_timeout", busy, 0);
    endtask

    task automatic count_ones(input int n, output int ones);
        ones = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            ones += int'(audio_out);
        end
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        vol_wr = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        int ones;
        int sum;
        int a;
        int v;
        int exp_bit;
        bit hist [64];

        reset    = 1'b1;
        aout     = 3'd0;
        vol_wr   = 1'b0;
        vol_data = 4'd0;
        #1;
        chk("rst_audio", audio_out, 0);
        chk("rst_vol", cur_vol, 0);
        chk("rst_busy", busy, 0);
        tick();
        reset = 1'b0;
        tick();

        // Latency from a clean accumulator: ones after j contributing clocks = floor(45*j/64).
        aout = 3'b000;
        write_vol(4'd15);
        wait_idle();
        chk("load15", cur_vol, 15);
        aout = 3'b111;
        for (int n = 1; n <= 8; n++) begin
            tick();
            exp_bit = (n == 1) ? 0 : ((n - 1) * 45) / 64 - ((n - 2) * 45) / 64;
            chk($sformatf("latency_%0d", n), audio_out, exp_bit);
        end

        // Full-scale mix: every sliding 64-clock window holds exactly 45 ones.
        repeat (4) tick();
        sum = 0;
        for (int i = 0; i < 64; i++) begin
            tick();
            hist[i] = audio_out;
            sum += int'(audio_out);
        end
        chk("win45_first", sum, 45);
        for (int i = 0; i < 64; i++) begin
            tick();
            sum = sum + int'(audio_out) - int'(hist[i]);
            hist[i] = audio_out;
            chk($sformatf("win45_slide_%0d", i), sum, 45);
        end

        // Single channel at volume 8, then silence within two clocks.
        aout = 3'b001;
        write_vol(4'd8);
        wait_idle();
        repeat (3) tick();
        count_ones(64, ones);
        chk("vol8_ch1", ones, 8);
        aout = 3'b000;
        repeat (2) tick();
        count_ones(20, ones);
        chk("silent", ones, 0);

        // Randomized constant-level segments against the ideal density count.
        for (int seg = 0; seg < 8; seg++) begin
            a = int'($urandom_range(7, 0));
            v = int'($urandom_range(15, 0));
            aout = 3'(a);
            write_vol(4'(v));
            wait_idle();
            chk($sformatf("rnd_vol_%0d", seg), cur_vol, v);
            repeat (3) tick();
            count_ones(64, ones);
            chk($sformatf("rnd_density_%0d", seg), ones, $countones(3'(a)) * v);
        end

`ifndef PSG_MIX_RAMP_EN
        write_vol(4'd9);
        chk("direct_load", cur_vol, 9);
        chk("direct_busy", busy, 0);
        write_vol(4'd7);
        chk("direct_load7", cur_vol, 7);
`else
        // Ramp 0 -> 4 with RAMP_DIV=4: one step every 4 clocks, busy until the last step.
        do_reset();
        write_vol(4'd4);
        for (int n = 0; n < 20; n++) begin
            chk($sformatf("ramp_up_vol_%0d", n), cur_vol, (n / 4 > 4) ? 4 : n / 4);
            chk($sformatf("ramp_up_busy_%0d", n), busy, (n < 16) ? 1 : 0);
            tick();
        end

        // Reverse mid-ramp at volume 5: the running divider sets the next step time.
        do_reset();
        write_vol(4'd12);
        repeat (20) tick();
        chk("rev_start", cur_vol, 5);
        write_vol(4'd2);
        for (int j = 0; j < 15; j++) begin
            chk($sformatf("rev_vol_%0d", j), cur_vol, (j < 3) ? 5 : (j < 7) ? 4 : (j < 11) ? 3 : 2);
            chk($sformatf("rev_busy_%0d", j), busy, (j < 11) ? 1 : 0);
            tick();
        end

        do_reset();
        write_vol(4'd12);
        repeat (28) tick();
        chk("mid_ramp7", cur_vol, 7);
        chk("mid_ramp_busy", busy, 1);
`endif
        // Asynchronous reset with a live mix; writes during reset are ignored.
        aout     = 3'b111;
        reset    = 1'b1;
        vol_wr   = 1'b1;
        vol_data = 4'd9;
        #1;
        chk("async_vol", cur_vol, 0);
        chk("async_busy", busy, 0);
        chk("async_audio", audio_out, 0);
        tick();
        tick();
        vol_wr = 1'b0;
        reset  = 1'b0;
        count_ones(10, ones);
        chk("post_rst_audio", ones, 0);
        chk("post_rst_vol", cur_vol, 0);
        chk("post_rst_busy", busy, 0);

        // Writing the current volume produces no step and no busy.
        write_vol(4'd0);
        chk("same0_busy", busy, 0);
        chk("same0_vol", cur_vol, 0);
        write_vol(4'd3);
        wait_idle();
        write_vol(4'd3);
        chk("same3_busy", busy, 0);
        chk("same3_vol", cur_vol, 3);
        repeat (6) tick();
        chk("same3_hold", cur_vol, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
